ttfs_aer_input_encoder: RTL and testbench

- Transmit end of the dense_1 AER input link into the SNN engine.
- Holds one 160-entry Q1.7 feature vector written by the host.
- On start, converts each feature to a time-to-first-spike (TTFS) time and emits one AER event per spiking feature, in ascending address order, over a 4-phase req/ack handshake.
- Asserts done after the last event is acknowledged. Supplies the engine's encoder req/time/addr/done inputs and consumes its ack.

---
 rtl/ttfs_aer_input_encoder.sv | 132 +++++++++++++
 tb/tb_ttfs_aer_input_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttfs_aer_input_encoder.sv
// ttfs_aer_input_encoder: holds a host-written feature vector and streams one
// time-to-first-spike AER event per spiking feature over a 4-phase req/ack link.
module ttfs_aer_input_encoder #(
    parameter int                         TIME_W      = 8,
    parameter int                         DATA_W      = 8,
    parameter int                         ADDR_W      = 10,
    parameter int                         IN_LEN      = 160,
    parameter logic signed [TIME_W-1:0]   T_MIN_Q17   = 8'sd0,
    parameter logic signed [TIME_W-1:0]   T_MAX_Q17   = 8'sd127,
    parameter bit                         SKIP_NONPOS = 1'b1,
    parameter int                         ACK_TIMEOUT = 1023
) (
    input  logic              local_clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_error,
    input  logic              i_feat_wr_en,
    input  logic [ADDR_W-1:0] i_feat_wr_addr,
    input  logic [DATA_W-1:0] i_feat_wr_data,
    output logic              o_aer_req,
    input  logic              i_aer_ack,
    output logic [TIME_W-1:0] o_aer_time,
    output logic [ADDR_W-1:0] o_aer_addr,
    output logic [ADDR_W-1:0] o_event_cnt
);
    localparam int IDX_W = $clog2(IN_LEN);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic signed [DATA_W+1:0] T_MAX_W = (DATA_W+2)'(T_MAX_Q17);
    localparam logic signed [DATA_W+1:0] SPAN    = (DATA_W+2)'(T_MAX_Q17) - (DATA_W+2)'(T_MIN_Q17);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(IN_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, FETCH, CALC, REQ, ACK_LOW, DONE, ERROR} state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        idx_q;
    logic [ADDR_W-1:0]        cnt_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [TIME_W-1:0]        time_q;
    logic [TMO_W-1:0]         tmo_q;
    logic                     req_q;
    logic [DATA_W-1:0]        mem [IN_LEN];
    logic signed [DATA_W-1:0] rd_q;
    logic signed [DATA_W+1:0] x_w;
    logic signed [DATA_W+1:0] xc;
    logic [TIME_W-1:0]        t_d;
    logic                     skip;

    // Two guard bits keep the clamp and subtraction free of overflow.
    assign x_w  = {{2{rd_q[DATA_W-1]}}, rd_q};
    assign xc   = (x_w < 0) ? '0 : ((x_w > SPAN) ? SPAN : x_w);
    assign t_d  = TIME_W'(T_MAX_W - xc);
    assign skip = SKIP_NONPOS && (x_w <= 0);

    assign o_busy      = !(state_q inside {IDLE, DONE, ERROR});
    assign o_done      = (state_q == DONE);
    assign o_error     = (state_q == ERROR);
    assign o_aer_req   = req_q;
    assign o_aer_time  = time_q;
    assign o_aer_addr  = addr_q;
    assign o_event_cnt = cnt_q;

    // Feature RAM is deliberately left uninitialised across reset.
    always_ff @(posedge local_clk) begin
        if (i_feat_wr_en && !o_busy && (i_feat_wr_addr < ADDR_W'(IN_LEN)))
            mem[i_feat_wr_addr[IDX_W-1:0]] <= i_feat_wr_data;
        if (state_q == FETCH)
            rd_q <= mem[idx_q[IDX_W-1:0]];
    end

    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            time_q  <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= FETCH;
                end
                FETCH: state_q <= CALC;
                CALC: if (!skip) begin
                    time_q  <= t_d;
                    addr_q  <= idx_q;
                    tmo_q   <= '0;
                    state_q <= REQ;
                end else if (idx_q == LAST) begin
                    state_q <= DONE;
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= FETCH;
                end
                // Ack is only honoured once req is visible on the link.
                REQ: if (!req_q) begin
                    req_q <= 1'b1;
                end else if (i_aer_ack) begin
                    cnt_q   <= cnt_q + 1'b1;
                    req_q   <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= ACK_LOW;
                end else if (tmo_q == TMO_MAX) begin
                    req_q   <= 1'b0;
                    state_q <= ERROR;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                ACK_LOW: if (!i_aer_ack) begin
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= FETCH;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_q <= ERROR;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                DONE, ERROR: if (!i_start) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ttfs_aer_input_encoder.sv
// tb_ttfs_aer_input_encoder: directed scoreboard bench for the TTFS AER encoder.
module tb_ttfs_aer_input_encoder;
    localparam int IN_LEN = 160;

    typedef struct {
        int a;
        int t;
    } ev_t;

    logic       local_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       o_done, o_busy, o_error;
    logic       i_feat_wr_en = 1'b0;
    logic [9:0] i_feat_wr_addr = '0;
    logic [7:0] i_feat_wr_data = '0;
    logic       o_aer_req;
    logic       i_aer_ack = 1'b0;
    logic [7:0] o_aer_time;
    logic [9:0] o_aer_addr;
    logic [9:0] o_event_cnt;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];

    ttfs_aer_input_encoder #(.ACK_TIMEOUT(15)) dut (
        .local_clk(local_clk), .rst_n(rst_n), .i_start(i_start),
        .o_done(o_done), .o_busy(o_busy), .o_error(o_error),
        .i_feat_wr_en(i_feat_wr_en), .i_feat_wr_addr(i_feat_wr_addr),
        .i_feat_wr_data(i_feat_wr_data), .o_aer_req(o_aer_req),
        .i_aer_ack(i_aer_ack), .o_aer_time(o_aer_time),
        .o_aer_addr(o_aer_addr), .o_event_cnt(o_event_cnt)
    );

    always #5 local_clk = ~local_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        i_feat_wr_en   = 1'b1;
        i_feat_wr_addr = 10'(a);
        i_feat_wr_data = 8'(d);
        @(negedge local_clk);
        i_feat_wr_en = 1'b0;
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < IN_LEN; i++) wr(i, d);
    endtask

    task automatic wait_req(output int w);
        w = 0;
        while (!o_aer_req && w < 400) begin
            @(negedge local_clk);
            w++;
        end
        if (!o_aer_req) chk("req_wait_expired", 0, 1);
    endtask

    task automatic serve(input int ack_dly, input int ack_hold, output int w);
        ev_t e;
        wait_req(w);
        if (!o_aer_req) return;
        if (sb.size() == 0) begin
            chk("unexpected_event", 1, 0);
            e = '{a: -1, t: -1};
        end else e = sb.pop_front();
        chk("ev_addr", o_aer_addr, e.a);
        chk("ev_time", o_aer_time, e.t);
        repeat (ack_dly) begin
            @(negedge local_clk);
            chk("req_held", o_aer_req, 1);
            chk("addr_stable", o_aer_addr, e.a);
            chk("time_stable", o_aer_time, e.t);
        end
        i_aer_ack = 1'b1;
        repeat (ack_hold) begin
            @(negedge local_clk);
            chk("req_low_while_ack", o_aer_req, 0);
            chk("addr_stable_ack", o_aer_addr, e.a);
            chk("time_stable_ack", o_aer_time, e.t);
        end
        i_aer_ack = 1'b0;
    endtask

    task automatic wait_done(input int exp_cnt);
        int k = 0;
        while (!o_done && k < 2000) begin
            @(negedge local_clk);
            k++;
        end
        chk("done", o_done, 1);
        chk("event_cnt", o_event_cnt, exp_cnt);
        chk("sb_empty", sb.size(), 0);
        repeat (3) @(negedge local_clk);
        chk("done_held_no_restart", o_done, 1);
        chk("not_busy_in_done", o_busy, 0);
        i_start = 1'b0;
        @(negedge local_clk);
        chk("done_cleared", o_done, 0);
    endtask

    initial begin
        int w;
        int k;
        repeat (3) @(negedge local_clk);
        rst_n = 1'b1;
        @(negedge local_clk);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_error", o_error, 0);
        chk("rst_req", o_aer_req, 0);
        chk("rst_cnt", o_event_cnt, 0);
        chk("rst_addr", o_aer_addr, 0);
        chk("rst_time", o_aer_time, 0);

        // All features 0.5 -> t = 127 - 64 = 63 for every address.
        fill(8'h40);
        for (int i = 0; i < IN_LEN; i++) sb.push_back('{a: i, t: 63});
        i_start = 1'b1;
        serve(1, 1, w);
        chk("first_req_latency", w, 4);
        chk("busy_in_scan", o_busy, 1);
        for (int i = 1; i < IN_LEN; i++) serve(1, 1, w);
        wait_done(160);

        // Mixed signs: only strictly positive features spike.
        fill(0);
        wr(0, 8'h7F); wr(1, 8'h00); wr(2, 8'h80); wr(3, 8'h10);
        sb.push_back('{a: 0, t: 0});
        sb.push_back('{a: 3, t: 111});
        i_start = 1'b1;
        serve(0, 1, w);
        serve(0, 1, w);
        wait_done(2);
        chk("no_req_after_done", o_aer_req, 0);

        // Slow receiver: ack after 5 cycles, held 3 cycles.
        fill(0);
        wr(5, 8'h40); wr(6, 8'h20);
        sb.push_back('{a: 5, t: 63});
        sb.push_back('{a: 6, t: 95});
        i_start = 1'b1;
        serve(5, 3, w);
        serve(5, 3, w);
        wait_done(2);

        // Receiver never acks: timeout 16 cycles after req rise.
        fill(0);
        wr(0, 8'h40);
        i_start = 1'b1;
        wait_req(w);
        k = 0;
        while (!o_error && k < 100) begin
            @(negedge local_clk);
            k++;
        end
        chk("timeout_cycles", k, 16);
        chk("error_req_low", o_aer_req, 0);
        chk("error_not_busy", o_busy, 0);
        repeat (2) @(negedge local_clk);
        chk("error_sticky", o_error, 1);
        i_start = 1'b0;
        @(negedge local_clk);
        chk("error_cleared", o_error, 0);
        sb.push_back('{a: 0, t: 63});
        i_start = 1'b1;
        serve(1, 1, w);
        wait_done(1);

        // Writes and start toggles while busy are ignored.
        fill(0);
        wr(0, 8'h40); wr(1, 8'h30);
        sb.push_back('{a: 0, t: 63});
        sb.push_back('{a: 1, t: 79});
        i_start = 1'b1;
        @(negedge local_clk);
        wr(2, 8'h7F);
        i_start = 1'b0;
        @(negedge local_clk);
        i_start = 1'b1;
        serve(1, 1, w);
        serve(1, 1, w);
        wait_done(2);
        sb.push_back('{a: 0, t: 63});
        sb.push_back('{a: 1, t: 79});
        i_start = 1'b1;
        serve(1, 1, w);
        serve(1, 1, w);
        wait_done(2);

        // Asynchronous reset in the middle of a request.
        i_start = 1'b1;
        wait_req(w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", o_aer_req, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_error", o_error, 0);
        chk("arst_time", o_aer_time, 0);
        chk("arst_addr", o_aer_addr, 0);
        chk("arst_cnt", o_event_cnt, 0);
        i_start = 1'b0;
        i_aer_ack = 1'b1;
        @(negedge local_clk);
        i_aer_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge local_clk);
        sb.push_back('{a: 0, t: 63});
        sb.push_back('{a: 1, t: 79});
        i_start = 1'b1;
        serve(1, 1, w);
        chk("restart_latency", w, 4);
        serve(1, 1, w);
        wait_done(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
